// File: rtl/waveform_readout_if.sv
// ---------------------------------------------------------------------------
// waveform_readout_if
// Byte stream from the waveform readout toward the Ethernet transmit path.
//   tx_data  [7:0] stream byte
//   tx_valid       tx_data is valid
//   tx_ready       downstream accepts the byte this cycle
//   tx_sop         first byte of a packet (qualified by tx_valid)
//   tx_eop         last byte of a packet (qualified by tx_valid)
// master: the byte producer (waveform_readout); slave: the packet transmitter.
// ---------------------------------------------------------------------------
interface waveform_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_sop;
  logic       tx_eop;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_sop,
    output tx_eop,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_sop,
    input  tx_eop,
    output tx_ready
  );
endinterface

// File: rtl/waveform_readout.sv
// ---------------------------------------------------------------------------
// waveform_readout
// Decodes single-byte host commands into the ADC handler control word,
// freezes a captured waveform, walks SampleNum across the frozen record and
// serialises it as one framed packet:
//   0xAA, 0x55, WAVE_LEN[15:8], WAVE_LEN[7:0], then every sample big-endian.
// Ports:
//   sys_clk, reset_n       clock, asynchronous active-low reset
//   cmd_valid/cmd_byte     command byte from the host receiver
//   cmd_ready              high only while idle
//   adcControl[7:0]        [0] acquire, [1] trig source, [2] trig slope,
//                          [3] delay, [7:4] zero
//   SampleNum[15:0]        sample index presented to the ADC handler
//   waveSample[15:0]       sample returned by the handler
//   tx (master modport)    framed byte stream
//   busy                   readout in progress
// ---------------------------------------------------------------------------
module waveform_readout #(
  parameter int WAVE_LEN       = 1000,
  parameter int SAMPLE_LATENCY = 2,
  parameter int ARM_CYCLES     = 4
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  input  logic [7:0]          cmd_byte,
  output logic                cmd_ready,
  output logic [7:0]          adcControl,
  output logic [15:0]         SampleNum,
  input  logic [15:0]         waveSample,
  waveform_readout_if.master  tx,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_HDR  = 3'd2,
    S_WAIT = 3'd3,
    S_HI   = 3'd4,
    S_LO   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [15:0] WAVE_LEN_W = 16'(WAVE_LEN);
  localparam logic [15:0] LAST_IDX   = 16'(WAVE_LEN - 1);
  localparam logic [7:0]  ARM_LAST   = 8'(ARM_CYCLES - 1);
  localparam logic [3:0]  LAT_LAST   = 4'(SAMPLE_LATENCY - 1);

  localparam logic [7:0] CMD_A  = 8'h41;
  localparam logic [7:0] CMD_TU = 8'h54;
  localparam logic [7:0] CMD_TL = 8'h74;
  localparam logic [7:0] CMD_SU = 8'h53;
  localparam logic [7:0] CMD_SL = 8'h73;
  localparam logic [7:0] CMD_DU = 8'h44;
  localparam logic [7:0] CMD_DL = 8'h64;

  // Header byte for a given position within the 4-byte packet header.
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'hAA;
      2'd1:    b = 8'h55;
      2'd2:    b = WAVE_LEN_W[15:8];
      2'd3:    b = WAVE_LEN_W[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;          // adcControl[3:0]
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [15:0] samp_num_q, samp_num_d;
  logic [7:0]  arm_cnt_q, arm_cnt_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] sample_q, sample_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_sop_q, tx_sop_d;
  logic        tx_eop_q, tx_eop_d;

  logic cmd_acc_s;
  logic tx_hs_s;
  logic last_s;
  logic arm_done_s;
  logic lat_done_s;

  assign cmd_acc_s  = cmd_valid && cmd_ready_q;
  assign tx_hs_s    = tx_valid_q && tx.tx_ready;
  assign last_s     = (samp_num_q == LAST_IDX);
  assign arm_done_s = (arm_cnt_q == ARM_LAST);
  assign lat_done_s = (lat_cnt_q == LAT_LAST);

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc_s && (cmd_byte == CMD_A)) state_d = S_ARM;
        else                                  state_d = S_IDLE;
      end
      S_ARM: begin
        if (arm_done_s) state_d = S_HDR;
        else            state_d = S_ARM;
      end
      S_HDR: begin
        if (tx_hs_s && (hdr_idx_q == 2'd3)) state_d = S_WAIT;
        else                                state_d = S_HDR;
      end
      S_WAIT: begin
        if (lat_done_s) state_d = S_HI;
        else            state_d = S_WAIT;
      end
      S_HI: begin
        if (tx_hs_s) state_d = S_LO;
        else         state_d = S_HI;
      end
      S_LO: begin
        if (tx_hs_s) state_d = last_s ? S_DONE : S_WAIT;
        else         state_d = S_LO;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is loaded one cycle ahead so
  // that it leaves the block straight from a flop.
  always_comb begin
    ctrl_d      = ctrl_q;
    busy_d      = busy_q;
    samp_num_d  = samp_num_q;
    arm_cnt_d   = arm_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    lat_cnt_d   = lat_cnt_q;
    sample_d    = sample_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    tx_sop_d    = tx_sop_q;
    tx_eop_d    = tx_eop_q;
    cmd_ready_d = (state_d == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (cmd_acc_s) begin
          case (cmd_byte)
            CMD_TU: ctrl_d[1] = 1'b1;
            CMD_TL: ctrl_d[1] = 1'b0;
            CMD_SU: ctrl_d[2] = 1'b1;
            CMD_SL: ctrl_d[2] = 1'b0;
            CMD_DU: ctrl_d[3] = 1'b1;
            CMD_DL: ctrl_d[3] = 1'b0;
            CMD_A: begin
              ctrl_d[0]  = 1'b1;
              busy_d     = 1'b1;
              samp_num_d = 16'd0;
              arm_cnt_d  = 8'd0;
            end
            default: ctrl_d = ctrl_q;   // unknown byte: swallowed
          endcase
        end else begin
          ctrl_d = ctrl_q;
        end
      end
      S_ARM: begin
        arm_cnt_d = arm_cnt_q + 8'd1;
        // Header byte 0 is presented the cycle ARM ends.
        if (arm_done_s) begin
          tx_valid_d = 1'b1;
          tx_data_d  = hdr_byte(2'd0);
          tx_sop_d   = 1'b1;
          hdr_idx_d  = 2'd0;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      S_HDR: begin
        if (tx_hs_s) begin
          tx_sop_d = 1'b0;
          if (hdr_idx_q == 2'd3) begin
            tx_valid_d = 1'b0;
            lat_cnt_d  = 4'd0;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
            tx_data_d = hdr_byte(hdr_idx_q + 2'd1);
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        // SampleNum has been stable for SAMPLE_LATENCY cycles here.
        if (lat_done_s) begin
          sample_d   = waveSample;
          tx_data_d  = waveSample[15:8];
          tx_valid_d = 1'b1;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      S_HI: begin
        if (tx_hs_s) begin
          tx_data_d = sample_q[7:0];
          tx_eop_d  = last_s;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      S_LO: begin
        if (tx_hs_s) begin
          tx_valid_d = 1'b0;
          tx_eop_d   = 1'b0;
          if (!last_s) begin
            samp_num_d = samp_num_q + 16'd1;
            lat_cnt_d  = 4'd0;
          end else begin
            samp_num_d = samp_num_q;
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        ctrl_d[0] = 1'b0;
        busy_d    = 1'b0;
      end
      default: begin
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q      <= 4'h0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      samp_num_q  <= 16'd0;
      arm_cnt_q   <= 8'd0;
      hdr_idx_q   <= 2'd0;
      lat_cnt_q   <= 4'd0;
      sample_q    <= 16'd0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_sop_q    <= 1'b0;
      tx_eop_q    <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      samp_num_q  <= samp_num_d;
      arm_cnt_q   <= arm_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      lat_cnt_q   <= lat_cnt_d;
      sample_q    <= sample_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_sop_q    <= tx_sop_d;
      tx_eop_q    <= tx_eop_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign adcControl  = {4'b0000, ctrl_q};
  assign SampleNum   = samp_num_q;
  assign busy        = busy_q;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_sop   = tx_sop_q;
  assign tx.tx_eop   = tx_eop_q;

endmodule

// File: tb/tb_waveform_readout.sv
// ---------------------------------------------------------------------------
// tb_waveform_readout
// Self-checking bench for waveform_readout (WAVE_LEN=4, ARM_CYCLES=4,
// SAMPLE_LATENCY=2). Command decoding is table driven; packets are checked
// through an expected-byte queue filled when a readout is started and
// drained by a stream monitor at every handshake.
// ---------------------------------------------------------------------------
module tb_waveform_readout;

  localparam int WL  = 4;
  localparam int ARM = 4;
  localparam int LAT = 2;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        cmd_ready;
  logic [7:0]  adcControl;
  logic [15:0] SampleNum;
  logic [15:0] waveSample;
  logic        busy;

  waveform_readout_if tx_if();

  waveform_readout #(
    .WAVE_LEN      (WL),
    .SAMPLE_LATENCY(LAT),
    .ARM_CYCLES    (ARM)
  ) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .cmd_ready (cmd_ready),
    .adcControl(adcControl),
    .SampleNum (SampleNum),
    .waveSample(waveSample),
    .tx        (tx_if),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Handler model: 0x1000+SampleNum, valid by the LAT-th edge after the
  // index changes (LAT-1 register stages).
  logic [15:0] wave_pipe = 16'h0000;
  always @(posedge sys_clk) wave_pipe <= 16'h1000 + SampleNum;
  assign waveSample = wave_pipe;

  int checks   = 0;
  int failures = 0;
  int xfer_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_packet();
    exp_t e;
    exp_q.delete();
    e = '{8'hAA, 1'b1, 1'b0}; exp_q.push_back(e);
    e = '{8'h55, 1'b0, 1'b0}; exp_q.push_back(e);
    e = '{8'h00, 1'b0, 1'b0}; exp_q.push_back(e);
    e = '{8'(WL), 1'b0, 1'b0}; exp_q.push_back(e);
    for (int i = 0; i < WL; i++) begin
      e = '{8'h10, 1'b0, 1'b0}; exp_q.push_back(e);
      e = '{8'(i), 1'b0, (i == WL - 1)}; exp_q.push_back(e);
    end
  endtask

  // tx_ready driver: held high or randomly toggled, changed just after the edge.
  bit rand_mode = 1'b0;
  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      tx_if.tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: scoreboard pop on handshake, stability check on stalls.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_sop, prev_eop;
  always @(negedge sys_clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_hold", {tx_if.tx_valid, tx_if.tx_data, tx_if.tx_sop, tx_if.tx_eop},
            {1'b1, prev_data, prev_sop, prev_eop});
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {tx_if.tx_data, tx_if.tx_sop, tx_if.tx_eop}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("stream_byte", {tx_if.tx_data, tx_if.tx_sop, tx_if.tx_eop},
              {e.data, e.sop, e.eop});
        end
        xfer_cnt++;
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      prev_sop   = tx_if.tx_sop;
      prev_eop   = tx_if.tx_eop;
    end
  end

  // One readout: start with 'A', watch latency, optional command blocking,
  // optional reset after abort_after bytes, then check the DONE/IDLE tail.
  task automatic run_readout(input bit rnd, input bit block_test, input int abort_after,
                             input logic [7:0] ctrl_base);
    int  cyc;
    bit  first_seen;
    bit  done;
    rand_mode = rnd;
    push_packet();
    xfer_cnt  = 0;
    cmd_valid = 1'b1;
    cmd_byte  = 8'h41;
    @(posedge sys_clk); #1;
    if (!block_test) cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("start_ctrl", adcControl, ctrl_base | 8'h01);
    chk("start_busy", busy, 1'b1);
    chk("start_ready", cmd_ready, 1'b0);
    chk("start_samplenum", SampleNum, 16'd0);
    cyc = 1; first_seen = 1'b0; done = 1'b0;
    while (!done && cyc < 400) begin
      if (!first_seen && tx_if.tx_valid) begin
        first_seen = 1'b1;
        chk("first_byte_latency", cyc, 1 + ARM);
      end
      if (block_test && busy) begin
        chk("blocked_ready", cmd_ready, 1'b0);
        chk("frozen_ctrl", adcControl[3:1], ctrl_base[3:1]);
      end
      if (tx_if.tx_valid && tx_if.tx_ready && tx_if.tx_eop) begin
        done = 1'b1;
      end else begin
        @(posedge sys_clk); #1;
        if (block_test && cyc == 10) cmd_byte = 8'h54;
        if (abort_after > 0 && xfer_cnt >= abort_after) begin
          #1 reset_n = 1'b0;
          #1;
          chk("abort_valid", tx_if.tx_valid, 1'b0);
          chk("abort_ctrl", adcControl, 8'h00);
          chk("abort_busy", busy, 1'b0);
          exp_q.delete();
          @(negedge sys_clk);
          @(posedge sys_clk); #1 reset_n = 1'b1;
          return;
        end
        @(negedge sys_clk);
        cyc++;
      end
    end
    if (!done) begin
      chk("readout_timeout", cyc, 0);
    end else begin
      @(negedge sys_clk);
      chk("done_busy", busy, 1'b1);
      chk("done_ready", cmd_ready, 1'b0);
      @(negedge sys_clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_ctrl", adcControl, ctrl_base);
      chk("idle_ready", cmd_ready, 1'b1);
      chk("idle_valid", tx_if.tx_valid, 1'b0);
      if (block_test) begin
        @(posedge sys_clk); #1 cmd_valid = 1'b0;
        @(negedge sys_clk);
        chk("pending_T_ctrl", adcControl, ctrl_base | 8'h02);
      end
    end
    chk("queue_empty", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] exp_ctrl;
  } cfg_vec_t;
  cfg_vec_t cfg_tbl[8];

  initial begin
    logic [7:0] prev_ctrl;
    cfg_tbl[0] = '{8'h54, 8'h02};   // T
    cfg_tbl[1] = '{8'h53, 8'h06};   // S
    cfg_tbl[2] = '{8'h44, 8'h0E};   // D
    cfg_tbl[3] = '{8'h73, 8'h0A};   // s
    cfg_tbl[4] = '{8'h5A, 8'h0A};   // Z: no effect
    cfg_tbl[5] = '{8'h74, 8'h08};   // t
    cfg_tbl[6] = '{8'h64, 8'h00};   // d
    cfg_tbl[7] = '{8'h53, 8'h04};   // S

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    repeat (2) @(negedge sys_clk);
    chk("rst_ctrl", adcControl, 8'h00);
    chk("rst_samplenum", SampleNum, 16'd0);
    chk("rst_tx", {tx_if.tx_data, tx_if.tx_valid, tx_if.tx_sop, tx_if.tx_eop}, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    @(posedge sys_clk); #1 reset_n = 1'b1;

    // Config commands on consecutive cycles, each checked one cycle later.
    prev_ctrl = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1;
      cmd_byte  = cfg_tbl[i].cmd;
      @(negedge sys_clk);
      chk("cfg_ready", cmd_ready, 1'b1);
      chk("cfg_ctrl", adcControl, prev_ctrl);
      chk("cfg_no_stream", {tx_if.tx_valid, busy}, 2'b00);
      prev_ctrl = cfg_tbl[i].exp_ctrl;
      @(posedge sys_clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("cfg_ctrl_final", adcControl, prev_ctrl);

    run_readout(1'b0, 1'b0, 0, 8'h04);   // plain readout, tx_ready high
    run_readout(1'b1, 1'b1, 0, 8'h04);   // backpressure + blocked commands
    run_readout(1'b0, 1'b0, 6, 8'h06);   // reset after 6 bytes
    run_readout(1'b0, 1'b0, 0, 8'h00);   // fresh packet after reset

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/waveform_readout.md
# waveform_readout

Host-side counterpart of the ADC handler: decodes single-byte host commands into the 8-bit ADC control word, freezes a captured waveform, walks the sample index across the frozen record, and serialises every sample into a framed byte stream toward the Ethernet transmit path. It sits between the command-byte receiver and the packet transmitter. It is the only driver of the handler's control word and sample-index inputs.

## Interface
- WAVE_LEN, 1000: samples per waveform record.
- SAMPLE_LATENCY, 2: sys_clk cycles from a SampleNum change to a valid waveSample; range 1–15.
- ARM_CYCLES, 4: cycles acquire is held before the first read, so the waveform freezes; range 1–255.

Ports:
- sys_clk  in  1  system clock; everything is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command byte present.
- cmd_byte  in  8  ASCII command.
- cmd_ready  out  1  block can accept a command.
- adcControl  out  8  control word: [0] acquire, [1] trigger source, [2] trigger slope, [3] delay, [7:4] always 0.
- SampleNum  out  16  sample index presented to the handler.
- waveSample  in  16  sample returned by the handler.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the byte.
- tx_sop  out  1  first byte of a packet; qualified by tx_valid.
- tx_eop  out  1  last byte of a packet; qualified by tx_valid.
- busy  out  1  readout in progress.

## Operation
- Reset values: adcControl=0x00, SampleNum=0, tx_data=0x00, tx_valid=0, tx_sop=0, tx_eop=0, busy=0, cmd_ready=1. The state machine resets to IDLE.
- A command is accepted when cmd_valid && cmd_ready. cmd_ready equals (state==IDLE).
- Configuration commands, accepted only in IDLE:
  - 'T'/'t' sets/clears bit 1.
  - 'S'/'s' sets/clears bit 2.
  - 'D'/'d' sets/clears bit 3.
  - Each takes effect the cycle after acceptance, and the bit persists until changed or reset.
- 'A' starts a readout. Any other byte is accepted and discarded with no effect.
- State machine:
  - IDLE: on 'A', set adcControl[0]=1, busy=1, SampleNum=0, arm counter=0 → ARM.
  - ARM: count ARM_CYCLES cycles → HDR.
  - HDR: send 4 header bytes 0xAA, 0x55, WAVE_LEN[15:8], WAVE_LEN[7:0]. tx_sop is set on 0xAA. After the 4th handshake → WAIT.
  - WAIT: SampleNum holds index i. Count SAMPLE_LATENCY cycles, then register waveSample into the sample register → HI.
  - HI: send sample[15:8].
  - LO: send sample[7:0].
    - If i==WAVE_LEN-1: tx_eop is set on this byte; after the handshake → DONE.
    - Otherwise: after the handshake, SampleNum←i+1 → WAIT.
  - DONE: adcControl[0]=0, busy=0 → IDLE, all in a single cycle.
- Packet length is always 4+2·WAVE_LEN bytes (2004 with the default). Samples are sent big-endian in index order 0..WAVE_LEN-1.
- adcControl[3:1] are frozen while busy, because commands are blocked.
- Reset asserted mid-readout:
  - Immediately clears tx_valid and adcControl.
  - The partial packet is abandoned without tx_eop. The downstream block discards packets that have no eop.

## Timing
- Config command accepted at cycle n → the adcControl bit changes at n+1.
- 'A' accepted at cycle n:
  - adcControl[0]=1 and busy=1 at n+1.
  - First header byte has tx_valid=1 at n+1+ARM_CYCLES.
- Stream handshake:
  - A byte transfers on the cycle tx_valid && tx_ready.
  - While tx_valid=1 && tx_ready=0, tx_data, tx_sop and tx_eop hold stable.
  - tx_valid never drops without a transfer, except on reset.
- With tx_ready held at 1:
  - Header takes 4 cycles. Each sample takes SAMPLE_LATENCY+2 cycles.
  - tx_valid is 0 during WAIT cycles.
- SampleNum changes only on the LO handshake cycle. It is stable for at least SAMPLE_LATENCY cycles before capture.
- Readout end:
  - Cycle after the final (eop) handshake: DONE.
  - The cycle after that: adcControl[0]=0, busy=0, cmd_ready=1.
- Backpressure on any byte extends the readout. No bytes or samples are dropped or duplicated.

## Test plan
- Reset, then 'T', 'S', 'D' on consecutive cycles → adcControl reads 0x02, 0x06, 0x0E, one cycle after each accept. Then 's' → 0x0A.
- WAVE_LEN=4, ARM_CYCLES=4, SAMPLE_LATENCY=2; handler model returns 0x1000+SampleNum with 2-cycle latency; tx_ready=1; 'A' → stream AA 55 00 04 10 00 10 01 10 02 10 03. tx_sop is on byte 0 and tx_eop on byte 11. First byte appears 5 cycles after accept.
- Same setup with tx_ready toggling randomly → identical byte sequence, and every byte is held stable while stalled.
- During a readout, cmd_valid with 'A' and 'T' → cmd_ready=0 and adcControl[3:1] unchanged. After DONE, cmd_ready=1 and the pending 'T' is accepted.
- Unknown byte 'Z' in IDLE → accepted (cmd_ready=1); adcControl and the stream are unchanged.
- reset_n pulsed low after 6 bytes → tx_valid=0 and adcControl=0x00 asynchronously. A new 'A' afterward produces a complete packet starting at 0xAA with SampleNum starting from 0.
